serpent_key_schedule: RTL and testbench

- Iterative Serpent subkey generator, directly upstream of key mixing in front of serpent_en_round.
- Accepts a 256-bit (already padded) user key and emits the 33 round subkeys K0..K32 in order, one per cycle when unstalled.
- Uses a valid/ready handshake so the round datapath can consume subkeys in lockstep with its round counter.

---
 rtl/serpent_pkg.sv | 43 ++++
 rtl/serpent_sboxes.sv | 31 +++
 rtl/serpent_key_schedule.sv | 113 +++++++++++
 tb/tb_serpent_key_schedule.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// Shared constants and helpers for the Serpent key schedule: prekey recurrence
// pieces, prekey-window slicing and the eight 4-bit S-box tables.
package serpent_pkg;

  localparam logic [31:0] PHI         = 32'h9E3779B9;
  localparam int          NUM_SUBKEYS = 33;
  localparam logic [5:0]  LAST_IDX    = 6'(NUM_SUBKEYS - 1);
  localparam int          WORD_W      = 32;
  localparam int          WIN_WORDS   = 8;
  localparam int          KEY_W       = WORD_W * WIN_WORDS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  // Row b holds S-box Sb in natural order: entry x is Sb(x).
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
    '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
    '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
    '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
    '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
    '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
    '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
    '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
  };

  function automatic logic [31:0] rotl11(input logic [31:0] x);
    return {x[20:0], x[31:21]};
  endfunction

  // Word k of the prekey window; word 0 is the oldest prekey w(j-8).
  function automatic logic [31:0] win_word(input logic [KEY_W-1:0] w, input int k);
    return w[WORD_W*k +: WORD_W];
  endfunction

  // Subkey g uses S-box (3 - g) mod 8; 3-bit wraparound does the modulo.
  function automatic logic [2:0] sbox_idx(input logic [2:0] g_lo);
    return 3'(3'd3 - g_lo);
  endfunction

endpackage

// File: rtl/serpent_sboxes.sv
// Bitsliced Serpent S-box layer: bit b of words 0..3 forms one nibble
// (word0 = LSB), and output bit j of that nibble lands in output word j.
module serpent_sboxes
  import serpent_pkg::*;
(
  input  logic [2:0]   i_box,
  input  logic [31:0]  i_w0,
  input  logic [31:0]  i_w1,
  input  logic [31:0]  i_w2,
  input  logic [31:0]  i_w3,
  output logic [127:0] o_y
);

  logic [3:0] nib;
  logic [3:0] sub;

  always_comb begin
    o_y = '0;
    nib = '0;
    sub = '0;
    for (int b = 0; b < 32; b++) begin
      nib = {i_w3[b], i_w2[b], i_w1[b], i_w0[b]};
      sub = SBOX[i_box][nib];
      o_y[b]      = sub[0];
      o_y[32 + b] = sub[1];
      o_y[64 + b] = sub[2];
      o_y[96 + b] = sub[3];
    end
  end

endmodule

// File: rtl/serpent_key_schedule.sv
// Iterative Serpent subkey generator: expands a 256-bit padded key into
// K0..K32, one per accepted beat, over a valid/ready output stage.
module serpent_key_schedule
  import serpent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [255:0] i_key,
  input  logic         i_start,
  input  logic         i_ready,
  output logic [127:0] o_subkey,
  output logic [5:0]   o_subkey_idx,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done
);

  // Handshake: a beat transfers on every clock edge where o_valid && i_ready;
  // while o_valid && !i_ready the subkey, its index and all state hold.

  ks_state_e      state_q, state_d;
  logic [255:0]   w_q, w_d;
  logic [5:0]     g_q, g_d;
  logic [127:0]   subkey_q, subkey_d;
  logic [5:0]     idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic [255:0]   win;
  logic [5:0]     gen;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   k_cur;
  logic           load;
  logic           last_hs;

  // In IDLE the step runs straight off i_key so K0 is registered on the start edge.
  always_comb begin
    win = (state_q == ST_IDLE) ? i_key : w_q;
    gen = (state_q == ST_IDLE) ? 6'd0 : g_q;
    n0  = rotl11(win_word(win, 0) ^ win_word(win, 3) ^ win_word(win, 5) ^
                 win_word(win, 7) ^ PHI ^ {24'd0, gen, 2'd0});
    n1  = rotl11(win_word(win, 1) ^ win_word(win, 4) ^ win_word(win, 6) ^
                 n0 ^ PHI ^ {24'd0, gen, 2'd1});
    n2  = rotl11(win_word(win, 2) ^ win_word(win, 5) ^ win_word(win, 7) ^
                 n1 ^ PHI ^ {24'd0, gen, 2'd2});
    n3  = rotl11(win_word(win, 3) ^ win_word(win, 6) ^ n0 ^
                 n2 ^ PHI ^ {24'd0, gen, 2'd3});
  end

  serpent_sboxes u_sboxes (
    .i_box (sbox_idx(gen[2:0])),
    .i_w0  (n0),
    .i_w1  (n1),
    .i_w2  (n2),
    .i_w3  (n3),
    .o_y   (k_cur)
  );

  always_comb begin
    load    = ((state_q == ST_IDLE) && i_start) ||
              ((state_q == ST_RUN) && (!valid_q || i_ready) && (g_q <= LAST_IDX));
    last_hs = (state_q == ST_RUN) && valid_q && i_ready &&
              (idx_q == LAST_IDX) && !load;

    state_d  = state_q;
    w_d      = w_q;
    g_d      = g_q;
    subkey_d = subkey_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    done_d   = 1'b0;

    if (load) begin
      state_d  = ST_RUN;
      w_d      = {n3, n2, n1, n0, win[255:128]};
      g_d      = gen + 6'd1;
      subkey_d = k_cur;
      idx_d    = gen;
      valid_d  = 1'b1;
    end else if (last_hs) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      g_q      <= '0;
      subkey_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      g_q      <= g_d;
      subkey_q <= subkey_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign o_subkey     = subkey_q;
  assign o_subkey_idx = idx_q;
  assign o_valid      = valid_q;
  assign o_busy       = (state_q == ST_RUN);
  assign o_done       = done_q;

endmodule

// File: tb/tb_serpent_key_schedule.sv
// Directed + randomized bench for serpent_key_schedule: a prekey/S-box reference
// model fills an expected-subkey queue that every output beat is checked against.
module tb_serpent_key_schedule;

  localparam logic [31:0] PHI_C = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key;
  logic         start;
  logic         ready;
  logic [127:0] o_subkey;
  logic [5:0]   o_subkey_idx;
  logic         o_valid;
  logic         o_busy;
  logic         o_done;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  int sbox_t [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  always #5 clk = ~clk;

  serpent_key_schedule dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key        (key),
    .i_start      (start),
    .i_ready      (ready),
    .o_subkey     (o_subkey),
    .o_subkey_idx (o_subkey_idx),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: full prekey array w(-8)..w(131), then S-box each 4-word group.
  function automatic void build_expected(input logic [255:0] k);
    logic [31:0]  w [140];
    logic [31:0]  t;
    logic [127:0] sk;
    logic [3:0]   nib;
    int           box;
    int           s;
    exp_q.delete();
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
    for (int i = 0; i < 132; i++) begin
      t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ PHI_C ^ 32'(i);
      w[i+8] = {t[20:0], t[31:21]};
    end
    for (int g = 0; g < 33; g++) begin
      box = (((3 - g) % 8) + 8) % 8;
      sk  = '0;
      for (int b = 0; b < 32; b++) begin
        nib = {w[4*g+11][b], w[4*g+10][b], w[4*g+9][b], w[4*g+8][b]};
        s   = sbox_t[box][nib];
        for (int j = 0; j < 4; j++) sk[32*j + b] = s[j];
      end
      exp_q.push_back(sk);
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},  o_valid, 0);
    chk({tag, "_busy"},   o_busy, 0);
    chk({tag, "_done"},   o_done, 0);
    chk({tag, "_subkey"}, o_subkey, 0);
    chk({tag, "_idx"},    o_subkey_idx, 0);
  endtask

  // mode 0: ready always high, 1: random stalls, 2: fixed stalls at idx 5/17/32.
  task automatic stream(input logic [255:0] k, input int mode, input int abort_at,
                        input bit spurious);
    int         cyc;
    int         beats;
    int         stall;
    int         last_idx;
    bit         spur_done;
    logic [5:0] exp_idx;
    build_expected(k);
    key = k; start = 1'b1; ready = 1'b1;
    cyc = 0; beats = 0; stall = 0; last_idx = -1; spur_done = 1'b0; exp_idx = '0;
    while (beats < 33 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      key   = rand_key();
      if (cyc == 1) chk("busy_after_start", o_busy, 1);
      chk("valid_no_bubble", o_valid, 1);
      if (o_valid) begin
        chk("idx", o_subkey_idx, exp_idx);
        chk("subkey", o_subkey, exp_q[0]);
        if (int'(o_subkey_idx) == abort_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          check_reset_outputs("mid_reset");
          exp_q.delete();
          return;
        end
        if (int'(o_subkey_idx) != last_idx) begin
          last_idx = int'(o_subkey_idx);
          if (mode == 1)
            stall = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
          else if (mode == 2)
            stall = (last_idx == 5) ? 3 : (last_idx == 17) ? 1 : (last_idx == 32) ? 10 : 0;
          else
            stall = 0;
        end
        if (spurious && !spur_done && o_subkey_idx == 6'd10) begin
          start     = 1'b1;
          spur_done = 1'b1;
        end
        ready = (stall == 0);
        if (stall > 0) stall--;
        if (ready) begin
          void'(exp_q.pop_front());
          beats++;
          exp_idx++;
        end
      end
    end
    chk("handshake_count", beats, 33);
    if (mode == 0) chk("k32_cycle", cyc, 33);
    @(posedge clk); #1;
    chk("done_pulse", o_done, 1);
    chk("busy_after_done", o_busy, 0);
    chk("valid_after_done", o_valid, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] nessie;
    rst = 1'b1; start = 1'b0; ready = 1'b0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    stream('0, 0, -1, 1'b0);

    nessie = '0;
    nessie[255] = 1'b1;
    stream(nessie, 0, -1, 1'b0);

    stream(rand_key(), 2, -1, 1'b0);
    stream(rand_key(), 0, -1, 1'b1);
    stream(rand_key(), 1, 20, 1'b0);
    stream(rand_key(), 1, -1, 1'b0);
    stream(rand_key(), 0, -1, 1'b0);
    stream(rand_key(), 1, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
